// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner and instruction fetch front end of the multi-cycle MIPS core.
// Ports: clk/resetn (async active-low); oIMemReq/oIMemAddr/iIMemAck/iIMemData fetch handshake;
//        oInstr/oOp/oValid/oPc/oPcPlus4 held instruction; iRetire/iTaken/iTarget next-PC; oMisalign, oBusErr.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  output logic [31:0] oInstr,
  output logic [5:0]  oOp,
  output logic        oValid,
  output logic [31:0] oPc,
  output logic [31:0] oPcPlus4,
  input  logic        iRetire,
  input  logic        iTaken,
  input  logic [31:0] iTarget,
  output logic        oMisalign,
  output logic        oBusErr
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_ERR} state_t;

  // Fetch addresses are always word aligned, even if the boot vector is not.
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  CNT_LAST   = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_pcp4;
  logic [31:0] r_addr;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_misalign;
  logic        r_buserr;

  logic [31:0] w_next_pc;
  logic        w_target_misal;

  assign w_target_misal = |iTarget[1:0];
  assign w_next_pc      = iTaken ? {iTarget[31:2], 2'b00} : r_pc + 32'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_BOOT;
      r_cnt      <= 8'd0;
      r_pc       <= RESET_PC_A;
      r_pcp4     <= RESET_PC_A + 32'd4;
      r_addr     <= 32'd0;
      r_instr    <= 32'd0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
          r_cnt   <= 8'd0;
        end
        S_REQ: begin
          // Timeout is checked before the ack so a last-cycle ack still errors.
          if (r_cnt == CNT_LAST) begin
            r_state  <= S_ERR;
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
          end else if (iIMemAck) begin
            r_state <= S_HOLD;
            r_instr <= iIMemData;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (iRetire) begin
            r_state    <= S_REQ;
            r_pc       <= w_next_pc;
            r_pcp4     <= w_next_pc + 32'd4;
            r_addr     <= w_next_pc;
            r_req      <= 1'b1;
            r_valid    <= 1'b0;
            r_cnt      <= 8'd0;
            r_misalign <= iTaken & w_target_misal;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign oIMemReq  = r_req;
  assign oIMemAddr = r_addr;
  assign oInstr    = r_instr;
  assign oOp       = r_instr[31:26];
  assign oValid    = r_valid;
  assign oPc       = r_pc;
  assign oPcPlus4  = r_pcp4;
  assign oMisalign = r_misalign;
  assign oBusErr   = r_buserr;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: the bench plays instruction memory and the retire logic,
// driving inputs on the falling edge and sampling outputs on the falling edge.
module tb_inst_fetch_unit;

  logic        clk;
  logic        resetn;
  logic        oIMemReq;
  logic [31:0] oIMemAddr;
  logic        iIMemAck;
  logic [31:0] iIMemData;
  logic [31:0] oInstr;
  logic [5:0]  oOp;
  logic        oValid;
  logic [31:0] oPc;
  logic [31:0] oPcPlus4;
  logic        iRetire;
  logic        iTaken;
  logic [31:0] iTarget;
  logic        oMisalign;
  logic        oBusErr;

  int checks   = 0;
  int failures = 0;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr),
    .iIMemAck(iIMemAck), .iIMemData(iIMemData),
    .oInstr(oInstr), .oOp(oOp), .oValid(oValid),
    .oPc(oPc), .oPcPlus4(oPcPlus4),
    .iRetire(iRetire), .iTaken(iTaken), .iTarget(iTarget),
    .oMisalign(oMisalign), .oBusErr(oBusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Serve one fetch: wait for the request, hold the ack off for 'dly' cycles, then return 'data'.
  task automatic fetch(input string tag, input int dly, input logic [31:0] data,
                       input logic [31:0] exp_addr);
    int n;
    int reqs;
    n = 0;
    while (oIMemReq !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'd0, oIMemReq}, 32'd1);
    chk({tag, "_addr"}, oIMemAddr, exp_addr);
    reqs = 1;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      if (oIMemReq === 1'b1 && oIMemAddr === exp_addr) reqs++;
    end
    iIMemAck  = 1'b1;
    iIMemData = data;
    @(negedge clk);
    iIMemAck  = 1'b0;
    iIMemData = 32'hDEAD_BEEF;
    chk({tag, "_reqcycles"}, reqs, dly + 1);
    chk({tag, "_valid"}, {31'd0, oValid}, 32'd1);
    chk({tag, "_reqdrop"}, {31'd0, oIMemReq}, 32'd0);
    chk({tag, "_instr"}, oInstr, data);
    chk({tag, "_op"}, {26'd0, oOp}, {26'd0, data[31:26]});
    chk({tag, "_buserr"}, {31'd0, oBusErr}, 32'd0);
  endtask

  // One-cycle retire pulse from S_HOLD; returns in the first request cycle of the next fetch.
  task automatic retire(input string tag, input logic taken, input logic [31:0] target,
                        input logic [31:0] exp_addr, input logic exp_mis);
    iRetire = 1'b1;
    iTaken  = taken;
    iTarget = target;
    @(negedge clk);
    iRetire = 1'b0;
    iTaken  = 1'b0;
    iTarget = 32'h0;
    chk({tag, "_valid0"}, {31'd0, oValid}, 32'd0);
    chk({tag, "_req"}, {31'd0, oIMemReq}, 32'd1);
    chk({tag, "_addr"}, oIMemAddr, exp_addr);
    chk({tag, "_pc"}, oPc, exp_addr);
    chk({tag, "_pcp4"}, oPcPlus4, exp_addr + 32'd4);
    chk({tag, "_misalign"}, {31'd0, oMisalign}, {31'd0, exp_mis});
  endtask

  initial begin
    int cnt;
    resetn    = 1'b0;
    iIMemAck  = 1'b0;
    iIMemData = 32'h0;
    iRetire   = 1'b0;
    iTaken    = 1'b0;
    iTarget   = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_req", {31'd0, oIMemReq}, 32'd0);
    chk("rst_addr", oIMemAddr, 32'd0);
    chk("rst_instr", oInstr, 32'd0);
    chk("rst_valid", {31'd0, oValid}, 32'd0);
    chk("rst_pc", oPc, 32'd0);
    chk("rst_pcp4", oPcPlus4, 32'd4);
    chk("rst_buserr", {31'd0, oBusErr}, 32'd0);
    chk("rst_misalign", {31'd0, oMisalign}, 32'd0);

    // Release just after a rising edge: one S_BOOT edge, then the request.
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("boot_noreq", {31'd0, oIMemReq}, 32'd0);
    @(negedge clk);

    // Zero-wait fetch of lw (opcode 0x23).
    fetch("f0", 0, 32'h8C53_0064, 32'h0);
    chk("f0_op23", {26'd0, oOp}, 32'h23);
    chk("f0_pc", oPc, 32'h0);
    chk("f0_pcp4", oPcPlus4, 32'h4);

    // Sequential retire, then a 3-wait-state fetch (4 request cycles).
    retire("r1", 1'b0, 32'h0, 32'h4, 1'b0);
    fetch("f1", 3, 32'h0000_0020, 32'h4);
    chk("f1_pc", oPc, 32'h4);

    // Ack while holding is ignored.
    iIMemAck  = 1'b1;
    iIMemData = 32'h1234_5678;
    @(negedge clk);
    iIMemAck  = 1'b0;
    chk("hold_ack_instr", oInstr, 32'h0000_0020);
    chk("hold_ack_valid", {31'd0, oValid}, 32'd1);

    // Aligned redirect to 0x100.
    retire("r2", 1'b1, 32'h0000_0100, 32'h100, 1'b0);
    fetch("f2", 0, 32'h1000_0003, 32'h100);

    // Misaligned redirect: 0x42 -> fetch 0x40, misalign pulse lasts one cycle.
    retire("r3", 1'b1, 32'h0000_0042, 32'h40, 1'b1);
    @(negedge clk);
    chk("r3_mis_pulse", {31'd0, oMisalign}, 32'd0);
    fetch("f3", 1, 32'h0800_0010, 32'h40);
    chk("f3_pc", oPc, 32'h40);

    // Top of the address space and wrap-around.
    retire("r4", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    fetch("f4", 0, 32'h2408_0001, 32'hFFFF_FFFC);
    chk("f4_pcp4_wrap", oPcPlus4, 32'h0);
    retire("r5", 1'b0, 32'h0, 32'h0, 1'b0);
    fetch("f5", 0, 32'h0000_0000, 32'h0);

    // A second retire pulse while requesting is dropped.
    retire("r6", 1'b0, 32'h0, 32'h4, 1'b0);
    iRetire = 1'b1;
    iTaken  = 1'b1;
    iTarget = 32'h0000_0200;
    @(negedge clk);
    iRetire = 1'b0;
    iTaken  = 1'b0;
    iTarget = 32'h0;
    chk("dbl_ret_addr", oIMemAddr, 32'h4);
    fetch("f6", 0, 32'hAC00_0000, 32'h4);
    chk("f6_pc", oPc, 32'h4);

    // Timeout: never ack except in the 16th request cycle, where the timeout wins.
    retire("r7", 1'b0, 32'h0, 32'h8, 1'b0);
    cnt = 0;
    while (oIMemReq === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 16) begin
        iIMemAck  = 1'b1;
        iIMemData = 32'h5555_AAAA;
      end
      @(negedge clk);
    end
    iIMemAck = 1'b0;
    chk("to_reqcycles", cnt, 32'd16);
    chk("to_buserr", {31'd0, oBusErr}, 32'd1);
    chk("to_req", {31'd0, oIMemReq}, 32'd0);
    chk("to_valid", {31'd0, oValid}, 32'd0);
    chk("to_instr", oInstr, 32'hAC00_0000);

    // Late ack and retire in S_ERR are ignored; the error is sticky.
    iIMemAck = 1'b1;
    iRetire  = 1'b1;
    @(negedge clk);
    iIMemAck = 1'b0;
    iRetire  = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, oBusErr}, 32'd1);
    chk("err_req", {31'd0, oIMemReq}, 32'd0);
    chk("err_valid", {31'd0, oValid}, 32'd0);
    chk("err_pc", oPc, 32'h8);

    // Reset clears the error; then reset again in the middle of a request.
    resetn = 1'b0;
    #1;
    chk("rst2_buserr", {31'd0, oBusErr}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_req", {31'd0, oIMemReq}, 32'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_req_async", {31'd0, oIMemReq}, 32'd0);
    chk("midrst_pc", oPc, 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("midrst_boot", {31'd0, oIMemReq}, 32'd0);
    @(negedge clk);
    fetch("f7", 0, 32'h8C53_0064, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front end of the multi-cycle MIPS core. Owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and holds each word stable for the opcode decoder and datapath until it retires.
- Applies the next-PC choice (PC+4 or redirect target) supplied by the branch/jump logic.
- Produces the opcode stream the control block consumes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for iIMemAck before declaring a bus error. Range 2..255.

Ports:
- clk  input  1  clock
- resetn  input  1  reset
- oIMemReq  output  1  fetch request to instruction memory
- oIMemAddr  output  32  fetch address; word aligned, bits[1:0] always 0
- iIMemAck  input  1  memory ack; iIMemData valid in the same cycle
- iIMemData  input  32  instruction word
- oInstr  output  32  held instruction
- oOp  output  6  oInstr[31:26], to the control block
- oValid  output  1  oInstr/oOp valid and held
- oPc  output  32  address of the held instruction
- oPcPlus4  output  32  oPc + 4, mod 2^32
- iRetire  input  1  single-cycle pulse: held instruction done, fetch the next
- iTaken  input  1  qualifies iRetire: redirect to iTarget
- iTarget  input  32  redirect target
- oMisalign  output  1  one-cycle pulse: a taken target had bits[1:0] != 0
- oBusErr  output  1  sticky: fetch timed out

Behaviour:
- Reset: clk and resetn, asynchronous, active-low.
  - All outputs are 0 during and after reset, except oPc = RESET_PC and oPcPlus4 = RESET_PC + 4.
  - State = S_BOOT; timeout counter = 0.
- States:
  - S_BOOT: one cycle, then go to S_REQ. oIMemReq = 0.
  - S_REQ: oIMemReq = 1 and oIMemAddr = pc.
    - On iIMemAck: oInstr <= iIMemData, go to S_HOLD.
    - Otherwise the counter increments.
    - When the counter reaches TIMEOUT-1 without an ack: go to S_ERR. The ack is not checked in that cycle.
  - S_HOLD: oValid = 1, oIMemReq = 0; oInstr, oOp and oPc are held stable.
    - On iRetire with iTaken = 0: pc <= pc + 4 (wrap at 2^32).
    - On iRetire with iTaken = 1: pc <= {iTarget[31:2], 2'b00}, and oMisalign pulses high for 1 cycle if iTarget[1:0] != 0.
    - In both iRetire cases: oValid <= 0, counter <= 0, go to S_REQ.
  - S_ERR: oBusErr = 1, oIMemReq = 0, oValid = 0. Only reset leaves this state.
- Handshake:
  - oIMemReq and oIMemAddr stay asserted and stable from entering S_REQ until the ack cycle inclusive.
  - The request is never withdrawn early.
  - After the ack, oIMemReq drops on the next cycle.
- Latency:
  - A zero-wait-state memory (ack in the first S_REQ cycle) gives oValid one cycle after the request cycle.
  - Retire to next oValid is 2 cycles minimum.
- Ignored inputs:
  - iRetire outside S_HOLD is ignored.
  - iTaken and iTarget are sampled only together with iRetire.
  - iIMemAck outside S_REQ is ignored.
- Simultaneous events:
  - Ack on the cycle the counter hits TIMEOUT-1: the timeout wins and the unit goes to S_ERR.
  - iRetire is a single pulse per instruction. A second pulse while in S_REQ is dropped.
- Reset mid-operation: any state returns to S_BOOT asynchronously, an outstanding request is abandoned, and oIMemReq drops immediately.
- oPc and oPcPlus4 are registered from pc and update on the cycle pc changes.
- oOp always equals oInstr[31:26], combinationally.

Test Plan:
- Reset, memory acks every request in 1 cycle returning 8C530064 -> first oIMemAddr = 0; oValid high with oOp = 6'h23 and oPc = 0; after iRetire, next oIMemAddr = 4.
- Memory delays ack by 3 cycles -> oIMemReq high for 4 consecutive cycles with oIMemAddr stable; oValid rises the cycle after the ack; no bus error.
- In S_HOLD at oPc = 0x100, iRetire with iTaken = 1 and iTarget = 0x0000_0042 -> oMisalign pulses high for 1 cycle; next oIMemAddr = 0x40; oPc = 0x40.
- oPc = 0xFFFF_FFFC, iRetire with iTaken = 0 -> next oIMemAddr = 0x0; oPcPlus4 wraps correctly.
- No ack for TIMEOUT = 16 cycles -> oBusErr rises after the 16th request cycle and oIMemReq drops; a late ack and iRetire are ignored; only resetn clears oBusErr.
- Assert resetn low during S_REQ -> oIMemReq drops asynchronously; after release, the fetch restarts at RESET_PC following one S_BOOT cycle.
